// File: rtl/fp_pkg.sv
// Shared floating-point definitions: class bit indices, format widths, field helpers.
package fp_pkg;

  // Bit positions inside the one-hot class vector {snan, qnan, inf, normal, subnormal, zero}
  typedef enum logic [2:0] {
    CLS_ZERO = 3'd0,
    CLS_SUB  = 3'd1,
    CLS_NORM = 3'd2,
    CLS_INF  = 3'd3,
    CLS_QNAN = 3'd4,
    CLS_SNAN = 3'd5
  } fp_class_e;

  localparam int unsigned FP_N_CLASS = 6;

  localparam int unsigned SP_EXP_W = 8;
  localparam int unsigned SP_MAN_W = 23;
  localparam int unsigned DP_EXP_W = 11;
  localparam int unsigned DP_MAN_W = 52;

  // Quiet bit is the MSB of the stored mantissa
  function automatic int unsigned quiet_bit_pos(input int unsigned man_w);
    return man_w - 1;
  endfunction

  // True when the low exp_w bits of e are all ones
  function automatic logic exp_all_ones(input logic [63:0] e, input int unsigned exp_w);
    logic [63:0] mask;
    mask = (64'd1 << exp_w) - 64'd1;
    return (e & mask) == mask;
  endfunction

endpackage

// File: rtl/fp_lzc.sv
// Leading-zero counter; an all-zero input yields WIDTH.
module fp_lzc #(
  parameter int unsigned WIDTH = 24
) (
  input  logic [WIDTH-1:0]             value,
  output logic [$clog2(WIDTH+1)-1:0]   count
);

  // Scan from the MSB, counting zeros until the first one
  always_comb begin
    logic found;
    found = 1'b0;
    count = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      if (!found) begin
        if (value[WIDTH-1-i]) found = 1'b1;
        else                  count = count + 1'b1;
      end
    end
  end

endmodule

// File: rtl/fp_operand_unpack.sv
// Two-stage IEEE-754 operand unpacker: classify + LZC, then subnormal normalise.
module fp_operand_unpack
  import fp_pkg::*;
#(
  parameter int unsigned EXP_W        = SP_EXP_W,
  parameter int unsigned MAN_W        = SP_MAN_W,
  parameter int unsigned N_OPS        = 2,
  parameter int unsigned NORM_SUBNORM = 1
) (
  input  logic                                    clk,
  input  logic                                    rst_n,
  input  logic                                    flush,
  input  logic                                    in_valid,
  output logic                                    in_ready,
  input  logic [N_OPS-1:0][EXP_W+MAN_W:0]         in_op,
  output logic                                    out_valid,
  input  logic                                    out_ready,
  output logic [N_OPS-1:0]                        out_sign,
  output logic [N_OPS-1:0][EXP_W+1:0]             out_exp,
  output logic [N_OPS-1:0][MAN_W:0]               out_sig,
  output logic [N_OPS-1:0][FP_N_CLASS-1:0]        out_class,
  output logic                                    out_any_nan,
  output logic                                    out_any_snan
);

  localparam int unsigned OP_W  = 1 + EXP_W + MAN_W;
  localparam int unsigned SIG_W = MAN_W + 1;
  localparam int unsigned XE_W  = EXP_W + 2;
  localparam int unsigned LZ_W  = $clog2(SIG_W + 1);
  localparam int unsigned QB    = quiet_bit_pos(MAN_W);

  logic [N_OPS-1:0]                  c1_sign;
  logic [N_OPS-1:0][FP_N_CLASS-1:0]  c1_cls;
  logic [N_OPS-1:0][SIG_W-1:0]       c1_sig;
  logic [N_OPS-1:0][LZ_W-1:0]        c1_lz;

  logic                              s1_valid;
  logic [N_OPS-1:0]                  s1_sign;
  logic [N_OPS-1:0][FP_N_CLASS-1:0]  s1_cls;
  logic [N_OPS-1:0][SIG_W-1:0]       s1_sig;
  logic [N_OPS-1:0][LZ_W-1:0]        s1_lz;
  logic [N_OPS-1:0][EXP_W-1:0]       s1_e;

  logic [N_OPS-1:0][SIG_W-1:0]       c2_sig;
  logic [N_OPS-1:0][XE_W-1:0]        c2_exp;
  logic                              c2_any_nan;
  logic                              c2_any_snan;

  logic out_adv, s1_adv, in_fire;

  assign out_adv  = !out_valid || out_ready;
  assign s1_adv   = !s1_valid || out_adv;
  assign in_ready = s1_adv && !flush;
  assign in_fire  = in_valid && in_ready;

  for (genvar g = 0; g < N_OPS; g++) begin : g_lzc
    fp_lzc #(.WIDTH(SIG_W)) u_lzc (
      .value ({1'b0, in_op[g][MAN_W-1:0]}),
      .count (c1_lz[g])
    );
  end

  // Per-operand classification and hidden-bit resolution
  always_comb begin
    logic [MAN_W-1:0] m;
    logic e_zero, e_ones, m_zero;
    c1_sign = '0;
    c1_cls  = '0;
    c1_sig  = '0;
    m       = '0;
    e_zero  = 1'b0;
    e_ones  = 1'b0;
    m_zero  = 1'b0;
    for (int unsigned i = 0; i < N_OPS; i++) begin
      m      = in_op[i][MAN_W-1:0];
      e_zero = (in_op[i][MAN_W +: EXP_W] == '0);
      e_ones = exp_all_ones(64'(in_op[i][MAN_W +: EXP_W]), EXP_W);
      m_zero = (m == '0);
      c1_sign[i]           = in_op[i][OP_W-1];
      c1_cls[i][CLS_ZERO]  = e_zero && m_zero;
      c1_cls[i][CLS_SUB]   = e_zero && !m_zero;
      c1_cls[i][CLS_NORM]  = !e_zero && !e_ones;
      c1_cls[i][CLS_INF]   = e_ones && m_zero;
      c1_cls[i][CLS_QNAN]  = e_ones && m[QB];
      c1_cls[i][CLS_SNAN]  = e_ones && !m_zero && !m[QB];
      c1_sig[i]            = {c1_cls[i][CLS_NORM], m};
    end
  end

  // Stage 1 register: holds while the output stage is stalled
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_sign  <= '0;
      s1_cls   <= '0;
      s1_sig   <= '0;
      s1_lz    <= '0;
      s1_e     <= '0;
    end else begin
      if (flush)       s1_valid <= 1'b0;
      else if (s1_adv) s1_valid <= in_fire;
      if (in_fire) begin
        s1_sign <= c1_sign;
        s1_cls  <= c1_cls;
        s1_sig  <= c1_sig;
        s1_lz   <= c1_lz;
        for (int unsigned i = 0; i < N_OPS; i++) s1_e[i] <= in_op[i][MAN_W +: EXP_W];
      end
    end
  end

  // Subnormal shift / exponent adjust and NaN summary flags
  always_comb begin
    c2_sig      = '0;
    c2_exp      = '0;
    c2_any_nan  = 1'b0;
    c2_any_snan = 1'b0;
    for (int unsigned i = 0; i < N_OPS; i++) begin
      c2_sig[i] = s1_sig[i];
      c2_exp[i] = XE_W'(s1_e[i]);
      if (s1_cls[i][CLS_SUB]) begin
        if (NORM_SUBNORM != 0) begin
          c2_sig[i] = s1_sig[i] << s1_lz[i];
          c2_exp[i] = XE_W'(1) - XE_W'(s1_lz[i]);
        end else begin
          c2_exp[i] = XE_W'(1);
        end
      end
      c2_any_nan  = c2_any_nan | s1_cls[i][CLS_QNAN] | s1_cls[i][CLS_SNAN];
      c2_any_snan = c2_any_snan | s1_cls[i][CLS_SNAN];
    end
  end

  // Output register: frozen while out_valid && !out_ready
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid    <= 1'b0;
      out_sign     <= '0;
      out_exp      <= '0;
      out_sig      <= '0;
      out_class    <= '0;
      out_any_nan  <= 1'b0;
      out_any_snan <= 1'b0;
    end else begin
      if (flush)        out_valid <= 1'b0;
      else if (out_adv) out_valid <= s1_valid;
      if (!flush && out_adv && s1_valid) begin
        out_sign     <= s1_sign;
        out_exp      <= c2_exp;
        out_sig      <= c2_sig;
        out_class    <= s1_cls;
        out_any_nan  <= c2_any_nan;
        out_any_snan <= c2_any_snan;
      end
    end
  end

endmodule

// File: tb/tb_fp_operand_unpack.sv
// Directed bench: one normalising and one non-normalising unpacker driven in parallel.
module tb_fp_operand_unpack;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic flush = 1'b0;
  logic in_valid = 1'b0;
  logic out_ready = 1'b1;
  logic [1:0][31:0] in_op = '0;

  logic u_in_ready, u_out_valid, u_any_nan, u_any_snan;
  logic [1:0] u_sign;
  logic [1:0][9:0] u_exp;
  logic [1:0][23:0] u_sig;
  logic [1:0][5:0] u_class;

  logic n_in_ready, n_out_valid, n_any_nan, n_any_snan;
  logic [1:0] n_sign;
  logic [1:0][9:0] n_exp;
  logic [1:0][23:0] n_sig;
  logic [1:0][5:0] n_class;

  int checks = 0;
  int errors = 0;

  localparam logic [5:0] C_ZERO = 6'b000001;
  localparam logic [5:0] C_SUB  = 6'b000010;
  localparam logic [5:0] C_NORM = 6'b000100;
  localparam logic [5:0] C_INF  = 6'b001000;
  localparam logic [5:0] C_QNAN = 6'b010000;
  localparam logic [5:0] C_SNAN = 6'b100000;

  always #5 clk = ~clk;

  fp_operand_unpack #(.EXP_W(8), .MAN_W(23), .N_OPS(2), .NORM_SUBNORM(1)) dut_norm (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(u_in_ready),
    .in_op(in_op), .out_valid(u_out_valid), .out_ready(out_ready), .out_sign(u_sign),
    .out_exp(u_exp), .out_sig(u_sig), .out_class(u_class), .out_any_nan(u_any_nan),
    .out_any_snan(u_any_snan)
  );

  fp_operand_unpack #(.EXP_W(8), .MAN_W(23), .N_OPS(2), .NORM_SUBNORM(0)) dut_raw (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(n_in_ready),
    .in_op(in_op), .out_valid(n_out_valid), .out_ready(out_ready), .out_sign(n_sign),
    .out_exp(n_exp), .out_sig(n_sig), .out_class(n_class), .out_any_nan(n_any_nan),
    .out_any_snan(n_any_snan)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #2;
    checks++; if (u_out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", u_out_valid); end
    checks++; if (u_sig !== '0) begin errors++; $display("FAIL reset_sig: got %h expected 0", u_sig); end
    checks++; if (u_exp !== '0) begin errors++; $display("FAIL reset_exp: got %h expected 0", u_exp); end
    checks++; if (u_class !== '0 || u_sign !== '0) begin errors++; $display("FAIL reset_class_sign: got %h/%b expected 0", u_class, u_sign); end
    checks++; if ({u_any_nan, u_any_snan} !== 2'b00) begin errors++; $display("FAIL reset_flags: got %b expected 00", {u_any_nan, u_any_snan}); end
    step();
    @(negedge clk);
    rst_n = 1'b1;
    step();
    checks++; if (u_in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", u_in_ready); end
    checks++; if (u_out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid_idle: got %b expected 0", u_out_valid); end
  endtask

  task automatic test_normal_zero();
    in_op[0] = 32'h3F80_0000; in_op[1] = 32'h0000_0000; in_valid = 1'b1;
    #1;
    checks++; if (u_in_ready !== 1'b1) begin errors++; $display("FAIL nz_in_ready: got %b expected 1", u_in_ready); end
    step();
    in_valid = 1'b0;
    checks++; if (u_out_valid !== 1'b0) begin errors++; $display("FAIL nz_latency1: got %b expected 0", u_out_valid); end
    step();
    checks++; if (u_out_valid !== 1'b1) begin errors++; $display("FAIL nz_latency2: got %b expected 1", u_out_valid); end
    checks++; if (u_class[0] !== C_NORM || u_exp[0] !== 10'd127 || u_sig[0] !== 24'h800000)
      begin errors++; $display("FAIL nz_op0: got cls %b exp %h sig %h expected 000100 07f 800000", u_class[0], u_exp[0], u_sig[0]); end
    checks++; if (u_class[1] !== C_ZERO || u_exp[1] !== 10'd0 || u_sig[1] !== 24'h0)
      begin errors++; $display("FAIL nz_op1: got cls %b exp %h sig %h expected 000001 000 000000", u_class[1], u_exp[1], u_sig[1]); end
    checks++; if (u_sign !== 2'b00 || u_any_nan !== 1'b0) begin errors++; $display("FAIL nz_sign_nan: got %b/%b expected 00/0", u_sign, u_any_nan); end
    step();
    checks++; if (u_out_valid !== 1'b0) begin errors++; $display("FAIL nz_drained: got %b expected 0", u_out_valid); end
  endtask

  task automatic test_subnormal();
    in_op[0] = 32'h0000_0001; in_op[1] = 32'h8040_0000; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    checks++; if (u_out_valid !== 1'b1 || u_class[0] !== C_SUB || u_class[1] !== C_SUB)
      begin errors++; $display("FAIL sub_class: got v %b cls %b %b expected 1 000010 000010", u_out_valid, u_class[0], u_class[1]); end
    checks++; if (u_sig[0] !== 24'h800000 || u_exp[0] !== 10'h3EA)
      begin errors++; $display("FAIL sub_norm_op0: got sig %h exp %h expected 800000 3ea", u_sig[0], u_exp[0]); end
    checks++; if (u_sig[1] !== 24'h800000 || u_exp[1] !== 10'h000 || u_sign !== 2'b10)
      begin errors++; $display("FAIL sub_norm_op1: got sig %h exp %h sign %b expected 800000 000 10", u_sig[1], u_exp[1], u_sign); end
    checks++; if (n_out_valid !== 1'b1 || n_sig[0] !== 24'h000001 || n_exp[0] !== 10'd1)
      begin errors++; $display("FAIL sub_raw_op0: got v %b sig %h exp %h expected 1 000001 001", n_out_valid, n_sig[0], n_exp[0]); end
    checks++; if (n_sig[1] !== 24'h400000 || n_exp[1] !== 10'd1 || n_sign !== 2'b10)
      begin errors++; $display("FAIL sub_raw_op1: got sig %h exp %h sign %b expected 400000 001 10", n_sig[1], n_exp[1], n_sign); end
    step();
  endtask

  task automatic test_specials();
    in_op[0] = 32'h7F80_0000; in_op[1] = 32'h7F80_0001; in_valid = 1'b1;
    step();
    in_op[0] = 32'h7FC0_0000; in_op[1] = 32'h3F80_0000;
    step();
    in_valid = 1'b0;
    checks++; if (u_out_valid !== 1'b1 || u_class[0] !== C_INF || u_class[1] !== C_SNAN)
      begin errors++; $display("FAIL spec1_class: got v %b cls %b %b expected 1 001000 100000", u_out_valid, u_class[0], u_class[1]); end
    checks++; if (u_exp[0] !== 10'h0FF || u_sig[0] !== 24'h0 || u_exp[1] !== 10'h0FF || u_sig[1] !== 24'h000001)
      begin errors++; $display("FAIL spec1_fields: got %h %h %h %h expected 0ff 000000 0ff 000001", u_exp[0], u_sig[0], u_exp[1], u_sig[1]); end
    checks++; if (u_any_snan !== 1'b1 || u_any_nan !== 1'b1)
      begin errors++; $display("FAIL spec1_flags: got nan %b snan %b expected 1 1", u_any_nan, u_any_snan); end
    step();
    checks++; if (u_out_valid !== 1'b1 || u_class[0] !== C_QNAN || u_class[1] !== C_NORM)
      begin errors++; $display("FAIL spec2_class: got v %b cls %b %b expected 1 010000 000100", u_out_valid, u_class[0], u_class[1]); end
    checks++; if (u_any_nan !== 1'b1 || u_any_snan !== 1'b0)
      begin errors++; $display("FAIL spec2_flags: got nan %b snan %b expected 1 0", u_any_nan, u_any_snan); end
    checks++; if (u_sig[0] !== 24'h400000 || u_exp[0] !== 10'h0FF)
      begin errors++; $display("FAIL spec2_qnan_fields: got sig %h exp %h expected 400000 0ff", u_sig[0], u_exp[0]); end
    step();
  endtask

  task automatic test_back_to_back();
    int sent, got;
    sent = 0;
    got = 0;
    for (int cyc = 0; cyc < 40 && got < 4; cyc++) begin
      in_valid  = (sent < 4);
      in_op[0]  = 32'h3F80_0000 + 32'(sent);
      in_op[1]  = 32'h4000_0000 + 32'(sent);
      out_ready = (cyc >= 5);
      #1;
      if (cyc == 2) begin
        checks++; if (u_in_ready !== 1'b0 || sent != 2)
          begin errors++; $display("FAIL bp_in_ready_fall: got ready %b after %0d accepts expected 0 after 2", u_in_ready, sent); end
      end
      if (cyc >= 2 && cyc <= 4) begin
        checks++; if (u_out_valid !== 1'b1 || u_sig[0] !== 24'h800000 || u_sig[1] !== 24'h800000 || u_exp[1] !== 10'd128)
          begin errors++; $display("FAIL bp_stall_stable: got v %b sig %h %h exp %h expected 1 800000 800000 080", u_out_valid, u_sig[0], u_sig[1], u_exp[1]); end
        checks++; if (u_in_ready !== 1'b0)
          begin errors++; $display("FAIL bp_stall_ready: got %b expected 0", u_in_ready); end
      end
      if (u_out_valid === 1'b1 && out_ready) begin
        checks++; if (u_sig[0] !== 24'h800000 + 24'(got) || u_sig[1] !== 24'h800000 + 24'(got) || u_exp[0] !== 10'd127)
          begin errors++; $display("FAIL bp_order: result %0d got sig %h %h exp %h expected %h %h 07f", got, u_sig[0], u_sig[1], u_exp[0], 24'h800000 + 24'(got), 24'h800000 + 24'(got)); end
        got++;
      end
      if (in_valid && u_in_ready === 1'b1) sent++;
      step();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    checks++; if (got != 4 || sent != 4)
      begin errors++; $display("FAIL bp_count: got %0d results %0d accepts expected 4 4", got, sent); end
    for (int k = 0; k < 3; k++) begin
      checks++; if (u_out_valid !== 1'b0)
        begin errors++; $display("FAIL bp_no_dup: got valid %b expected 0", u_out_valid); end
      step();
    end
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    in_op[0] = 32'h3F80_0000; in_op[1] = 32'h3F80_0000; in_valid = 1'b1;
    step();
    in_op[0] = 32'h4000_0000;
    step();
    checks++; if (u_out_valid !== 1'b1)
      begin errors++; $display("FAIL flush_pre_valid: got %b expected 1", u_out_valid); end
    in_op[0] = 32'h4040_0000;
    flush = 1'b1;
    #1;
    checks++; if (u_in_ready !== 1'b0)
      begin errors++; $display("FAIL flush_in_ready: got %b expected 0", u_in_ready); end
    step();
    flush = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    #1;
    checks++; if (u_out_valid !== 1'b0 || u_in_ready !== 1'b1)
      begin errors++; $display("FAIL flush_cleared: got valid %b ready %b expected 0 1", u_out_valid, u_in_ready); end
    for (int k = 0; k < 4; k++) begin
      step();
      checks++; if (u_out_valid !== 1'b0)
        begin errors++; $display("FAIL flush_no_emit: got valid %b expected 0", u_out_valid); end
    end
  endtask

  task automatic test_reset_midstream();
    out_ready = 1'b1;
    in_op[0] = 32'hBF80_0000; in_op[1] = 32'h7FC0_0000; in_valid = 1'b1;
    step();
    step();
    in_valid = 1'b0;
    checks++; if (u_out_valid !== 1'b1 || u_sig[0] !== 24'h800000)
      begin errors++; $display("FAIL rst_pre_valid: got v %b sig %h expected 1 800000", u_out_valid, u_sig[0]); end
    rst_n = 1'b0;
    #1;
    checks++; if (u_out_valid !== 1'b0 || u_sig !== '0 || u_exp !== '0 || u_class !== '0 || u_sign !== '0 || u_any_nan !== 1'b0)
      begin errors++; $display("FAIL rst_async_clear: got v %b sig %h exp %h cls %h sign %b nan %b expected all 0", u_out_valid, u_sig, u_exp, u_class, u_sign, u_any_nan); end
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step();
      checks++; if (u_out_valid !== 1'b0)
        begin errors++; $display("FAIL rst_no_emit: got valid %b expected 0", u_out_valid); end
    end
  endtask

  initial begin
    test_reset();
    test_normal_zero();
    test_subnormal();
    test_specials();
    test_back_to_back();
    test_flush();
    test_reset_midstream();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
